// File: rtl/midi_pkg.sv
// Shared MIDI constants and receiver state encoding for the polyphonic MIDI receiver.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF      = 4'h8;
    localparam logic [3:0] ST_NOTE_ON       = 4'h9;
    localparam logic [3:0] ST_CC            = 4'hB;

    localparam logic [6:0] CC_SUSTAIN       = 7'd64;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 2-FF input synchroniser, mid-bit sampling, 8N1 LSB-first framing.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 31_250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       framing_err_o
);

    localparam int PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF   = PERIOD / 2;
    localparam int CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(PERIOD - 1);

    logic            sync1_q, sync2_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Synchroniser flops reset to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_o        = shift_q;
    assign byte_valid_o  = valid_q;
    assign framing_err_o = ferr_q;

endmodule

// File: rtl/midi_poly_rx.sv
// MIDI receiver with running-status parser and polyphonic voice allocator (retrigger, oldest-steal).
// Optional sustain pedal (CC64) handling is enabled by defining SUSTAIN_PEDAL_EN.
module midi_poly_rx
    import midi_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 31_250,
    parameter int NUM_VOICES       = 8,
    parameter int VEL_WIDTH        = 3,
    parameter int MIDI_CHANNEL     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              data_in,
    output logic [NUM_VOICES-1:0]             on_out,
    output logic [NUM_VOICES*7-1:0]           note_out,
    output logic [NUM_VOICES*VEL_WIDTH-1:0]   velocity_out,
    output logic                              byte_valid,
    output logic                              framing_err
);

    localparam int AW = $clog2(NUM_VOICES);
    localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);
    localparam bit            OMNI    = (MIDI_CHANNEL > 15);
    localparam logic [3:0]    CHAN    = 4'(MIDI_CHANNEL % 16);

    logic [7:0] rx_byte;
    logic       rx_valid;

    midi_uart_rx #(
        .INPUT_CLOCK_FREQ (INPUT_CLOCK_FREQ),
        .BAUD_RATE        (BAUD_RATE)
    ) u_uart (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .byte_o        (rx_byte),
        .byte_valid_o  (rx_valid),
        .framing_err_o (framing_err)
    );

    assign byte_valid = rx_valid;

    logic [7:0]            status_q, status_d;
    logic                  idx_q, idx_d;
    logic [6:0]            data0_q, data0_d;
    logic [NUM_VOICES-1:0] on_q, on_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [VEL_WIDTH-1:0]  vel_q  [NUM_VOICES];
    logic [VEL_WIDTH-1:0]  vel_d  [NUM_VOICES];
    logic [AW-1:0]         age_q  [NUM_VOICES];
    logic [AW-1:0]         age_d  [NUM_VOICES];
`ifdef SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0] held_q, held_d;
    logic                  sustain_q, sustain_d;
`endif

    logic                 fire;
    logic                 chan_ok;
    logic                 is_note_on, is_note_off, is_cc;
    logic [VEL_WIDTH-1:0] vel_quant;

    assign chan_ok = OMNI || (status_q[3:0] == CHAN);

    // Status/running-status tracking; fire marks the second data byte of a message.
    always_comb begin
        status_d = status_q;
        idx_d    = idx_q;
        data0_d  = data0_q;
        fire     = 1'b0;
        if (rx_valid) begin
            if (rx_byte[7]) begin
                if (rx_byte[7:4] != 4'hF) begin
                    status_d = rx_byte;
                    idx_d    = 1'b0;
                end else if (!rx_byte[3]) begin
                    status_d = '0;
                    idx_d    = 1'b0;
                end
            end else if (status_q[7]) begin
                if (!idx_q) begin
                    data0_d = rx_byte[6:0];
                    idx_d   = 1'b1;
                end else begin
                    idx_d = 1'b0;
                    fire  = chan_ok;
                end
            end
        end
    end

    assign is_note_on  = fire && (status_q[7:4] == ST_NOTE_ON) && (rx_byte[6:0] != 7'd0);
    assign is_note_off = fire && ((status_q[7:4] == ST_NOTE_OFF) ||
                                  ((status_q[7:4] == ST_NOTE_ON) && (rx_byte[6:0] == 7'd0)));
    assign is_cc       = fire && (status_q[7:4] == ST_CC);

    always_comb begin
        vel_quant = rx_byte[6 -: VEL_WIDTH];
        if ((vel_quant == '0) && (rx_byte[6:0] != 7'd0)) begin
            vel_quant = VEL_WIDTH'(1);
        end
    end

    logic          hit_found, free_found;
    logic [AW-1:0] hit_idx, free_idx, steal_idx, steal_age, sel_idx;

    // Priority: retrigger a held-on copy of the note, else lowest free, else oldest (lowest index on ties).
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        steal_idx  = '0;
        steal_age  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (on_q[i] && (note_q[i] == data0_q) && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = AW'(i);
            end
            if (!on_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = AW'(i);
            end
            if (age_q[i] > steal_age) begin
                steal_age = age_q[i];
                steal_idx = AW'(i);
            end
        end
        sel_idx = hit_found ? hit_idx : (free_found ? free_idx : steal_idx);
    end

    always_comb begin
        on_d   = on_q;
        note_d = note_q;
        vel_d  = vel_q;
        age_d  = age_q;
`ifdef SUSTAIN_PEDAL_EN
        held_d    = held_q;
        sustain_d = sustain_q;
`endif
        if (is_note_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (AW'(i) == sel_idx) begin
                    on_d[i]   = 1'b1;
                    note_d[i] = data0_q;
                    vel_d[i]  = vel_quant;
                    age_d[i]  = '0;
`ifdef SUSTAIN_PEDAL_EN
                    held_d[i] = 1'b0;
`endif
                end else if (on_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
        if (is_note_off) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (on_q[i] && (note_q[i] == data0_q)) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (sustain_q) begin
                        held_d[i] = 1'b1;
                    end else begin
                        on_d[i] = 1'b0;
                    end
`else
                    on_d[i] = 1'b0;
`endif
                end
            end
        end
        if (is_cc) begin
            case (data0_q)
                CC_ALL_NOTES_OFF: begin
                    on_d = '0;
`ifdef SUSTAIN_PEDAL_EN
                    held_d = '0;
`endif
                end
                CC_SUSTAIN: begin
`ifdef SUSTAIN_PEDAL_EN
                    sustain_d = rx_byte[6];
                    if (!rx_byte[6]) begin
                        on_d   = on_q & ~held_q;
                        held_d = '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
            idx_q    <= 1'b0;
            data0_q  <= '0;
            on_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
`ifdef SUSTAIN_PEDAL_EN
            held_q    <= '0;
            sustain_q <= 1'b0;
`endif
        end else begin
            status_q <= status_d;
            idx_q    <= idx_d;
            data0_q  <= data0_d;
            on_q     <= on_d;
            note_q   <= note_d;
            vel_q    <= vel_d;
            age_q    <= age_d;
`ifdef SUSTAIN_PEDAL_EN
            held_q    <= held_d;
            sustain_q <= sustain_d;
`endif
        end
    end

    assign on_out = on_q;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_out
        assign note_out[gi*7 +: 7]                 = note_q[gi];
        assign velocity_out[gi*VEL_WIDTH +: VEL_WIDTH] = vel_q[gi];
    end

endmodule

// File: tb/tb_midi_poly_rx.sv
// Bench for midi_poly_rx: an omni instance and a channel-2 instance share one serial line,
// and a message-level voice model is compared against both after every byte.
module tb_midi_poly_rx;

    localparam int NV     = 8;
    localparam int VW     = 3;
    localparam int P      = 16;
    localparam int CLK_HZ = P * 31_250;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_in = 1'b1;

    logic [NV-1:0]    on0, on1;
    logic [NV*7-1:0]  note0, note1;
    logic [NV*VW-1:0] vel0, vel1;
    logic             bv0, bv1, fe0, fe1;

    midi_poly_rx #(
        .INPUT_CLOCK_FREQ (CLK_HZ), .BAUD_RATE (31_250), .NUM_VOICES (NV),
        .VEL_WIDTH (VW), .MIDI_CHANNEL (16)
    ) dut_omni (
        .clk (clk), .rst (rst), .data_in (data_in), .on_out (on0), .note_out (note0),
        .velocity_out (vel0), .byte_valid (bv0), .framing_err (fe0)
    );

    midi_poly_rx #(
        .INPUT_CLOCK_FREQ (CLK_HZ), .BAUD_RATE (31_250), .NUM_VOICES (NV),
        .VEL_WIDTH (VW), .MIDI_CHANNEL (2)
    ) dut_ch2 (
        .clk (clk), .rst (rst), .data_in (data_in), .on_out (on1), .note_out (note1),
        .velocity_out (vel1), .byte_valid (bv1), .framing_err (fe1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_on   [2][NV];
    int m_note [2][NV];
    int m_vel  [2][NV];
    int m_age  [2][NV];
    int m_held [2][NV];
    int m_sus    [2];
    int m_status [2];
    int m_idx    [2];
    int m_d0     [2];
    int chan     [2] = '{16, 2};

    int exp_bv = 0;
    int exp_fe = 0;
    int got_bv [2] = '{0, 0};
    int got_fe [2] = '{0, 0};
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < NV; v++) begin
                m_on[d][v] = 0; m_note[d][v] = 0; m_vel[d][v] = 0;
                m_age[d][v] = 0; m_held[d][v] = 0;
            end
            m_sus[d] = 0; m_status[d] = 0; m_idx[d] = 0; m_d0[d] = 0;
        end
    endtask

    task automatic note_on(input int d, input int note, input int vel);
        int v;
        int q;
        v = -1;
        for (int i = 0; i < NV; i++) if (v < 0 && m_on[d][i] != 0 && m_note[d][i] == note) v = i;
        for (int i = 0; i < NV; i++) if (v < 0 && m_on[d][i] == 0) v = i;
        if (v < 0) begin
            v = 0;
            for (int i = 1; i < NV; i++) if (m_age[d][i] > m_age[d][v]) v = i;
        end
        for (int i = 0; i < NV; i++)
            if (i != v && m_on[d][i] != 0 && m_age[d][i] < NV - 1) m_age[d][i]++;
        q = vel / (1 << (7 - VW));
        if (q == 0) q = 1;
        m_on[d][v] = 1; m_note[d][v] = note; m_vel[d][v] = q;
        m_age[d][v] = 0; m_held[d][v] = 0;
    endtask

    task automatic note_off(input int d, input int note);
        for (int i = 0; i < NV; i++) begin
            if (m_on[d][i] != 0 && m_note[d][i] == note) begin
                if (m_sus[d] != 0) m_held[d][i] = 1;
                else m_on[d][i] = 0;
            end
        end
    endtask

    task automatic model_byte(input int d, input int b);
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin m_status[d] = 0; m_idx[d] = 0; return; end
        if (b >= 'h80) begin m_status[d] = b; m_idx[d] = 0; return; end
        if (m_status[d] == 0) return;
        if (m_idx[d] == 0) begin m_d0[d] = b; m_idx[d] = 1; return; end
        m_idx[d] = 0;
        if (chan[d] != 16 && (m_status[d] % 16) != chan[d]) return;
        case (m_status[d] / 16)
            9:  if (b != 0) note_on(d, m_d0[d], b); else note_off(d, m_d0[d]);
            8:  note_off(d, m_d0[d]);
            11: begin
                if (m_d0[d] == 123) begin
                    for (int i = 0; i < NV; i++) begin m_on[d][i] = 0; m_held[d][i] = 0; end
                end
`ifdef SUSTAIN_PEDAL_EN
                if (m_d0[d] == 64) begin
                    m_sus[d] = (b >= 64) ? 1 : 0;
                    if (b < 64)
                        for (int i = 0; i < NV; i++)
                            if (m_held[d][i] != 0) begin m_on[d][i] = 0; m_held[d][i] = 0; end
                end
`endif
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (bv0) got_bv[0]++;
        if (bv1) got_bv[1]++;
        if (fe0) got_fe[0]++;
        if (fe1) got_fe[1]++;
    end

    always @(negedge clk) begin : compare_proc
        logic [63:0] e_on, e_note, e_vel;
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                e_on = '0; e_note = '0; e_vel = '0;
                for (int v = 0; v < NV; v++) begin
                    e_on[v]             = (m_on[d][v] != 0);
                    e_note[v*7 +: 7]    = 7'(m_note[d][v]);
                    e_vel[v*VW +: VW]   = VW'(m_vel[d][v]);
                end
                check($sformatf("dut%0d on_out", d), (d == 0) ? 64'(on0) : 64'(on1), e_on);
                check($sformatf("dut%0d note_out", d), (d == 0) ? 64'(note0) : 64'(note1), e_note);
                check($sformatf("dut%0d velocity_out", d), (d == 0) ? 64'(vel0) : 64'(vel1), e_vel);
            end
        end
    end

    task automatic window();
        check_en = 1'b1;
        cyc(4);
        check_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d byte_valid count", d), 64'(got_bv[d]), 64'(exp_bv));
            check($sformatf("dut%0d framing_err count", d), 64'(got_fe[d]), 64'(exp_fe));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        data_in = 1'b0;
        cyc(P);
        for (int k = 0; k < 8; k++) begin
            data_in = b[k];
            cyc(P);
        end
        if (good_stop) begin
            data_in = 1'b1;
            cyc(P);
            exp_bv++;
            model_byte(0, int'(b));
            model_byte(1, int'(b));
        end else begin
            data_in = 1'b0;
            cyc(P / 2 + 6);
            data_in = 1'b1;
            cyc(P);
            exp_fe++;
        end
        $display("tx 0x%02h stop=%0d on0=%02h on1=%02h", b, good_stop, on0, on1);
        window();
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
    endtask

    initial begin
        model_reset();
        cyc(5);
        check("reset on_out", 64'(on0), 64'h0);
        check("reset note_out", 64'(note0), 64'h0);
        check("reset velocity_out", 64'(vel0), 64'h0);
        check("reset ch2 on_out", 64'(on1), 64'h0);
        rst = 1'b0;
        cyc(5);
        window();

        // Basic note on / off
        send3(8'h90, 8'h3C, 8'h64);
        check("T1 on_out", 64'(on0), 64'h01);
        check("T1 note v0", 64'(note0[6:0]), 64'd60);
        check("T1 vel v0", 64'(vel0[2:0]), 64'd6);
        send3(8'h80, 8'h3C, 8'h00);
        check("T1 off on_out", 64'(on0), 64'h00);
        check("T1 off note v0", 64'(note0[6:0]), 64'd60);

        // Fill all voices with running status, then steal oldest twice
        send_byte(8'h90, 1'b1);
        for (int n = 40; n <= 49; n++) begin
            send_byte(8'(n), 1'b1);
            send_byte(8'h7F, 1'b1);
        end
        check("T2 on_out", 64'(on0), 64'hFF);
        check("T2 steal v0", 64'(note0[6:0]), 64'd48);
        check("T2 steal v1", 64'(note0[13:7]), 64'd49);
        check("T2 note v7", 64'(note0[55:49]), 64'd47);
        send3(8'hB0, 8'h7B, 8'h00);
        check("T2 all notes off", 64'(on0), 64'h00);

        // Retrigger of a held note and velocity quantisation
        send3(8'h90, 8'h3C, 8'h7F);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h10, 1'b1);
        check("T3 one voice", 64'(on0), 64'h01);
        check("T3 vel v0", 64'(vel0[2:0]), 64'd1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h05, 1'b1);
        check("T3 forced vel", 64'(vel0[2:0]), 64'd1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        check("T3 vel0 off", 64'(on0), 64'h00);

        // Channel filtering
        send3(8'h91, 8'h3C, 8'h64);
        check("T4 ch1 ignored by ch2", 64'(on1), 64'h00);
        check("T4 ch1 accepted by omni", 64'(on0), 64'h01);
        send3(8'h92, 8'h3C, 8'h64);
        check("T4 ch2 accepted", 64'(on1), 64'h01);
        send3(8'hB0, 8'h7B, 8'h00);
        send3(8'hB2, 8'h7B, 8'h00);
        check("T4 cleared ch2", 64'(on1), 64'h00);

        // Realtime byte mid-message and a framing error
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h64, 1'b1);
        check("T5 realtime ignored", 64'(on0), 64'h01);
        send_byte(8'hB0, 1'b0);
        send_byte(8'h7B, 1'b1);
        send_byte(8'h00, 1'b1);
        check("T5 bad byte discarded", 64'(on0), 64'h01);
        check("T5 framing_err count", 64'(got_fe[0]), 64'd1);

        // Sustain pedal
        send3(8'hB0, 8'h7B, 8'h00);
        send3(8'h90, 8'h3C, 8'h64);
        send3(8'hB0, 8'h40, 8'h7F);
        send3(8'h80, 8'h3C, 8'h00);
`ifdef SUSTAIN_PEDAL_EN
        check("T6 sustained", 64'(on0), 64'h01);
`else
        check("T6 no sustain", 64'(on0), 64'h00);
`endif
        send3(8'hB0, 8'h40, 8'h00);
        check("T6 pedal up", 64'(on0), 64'h00);

        // Asynchronous reset in the middle of a byte
        send3(8'h90, 8'h3C, 8'h64);
        data_in = 1'b0;
        cyc(P);
        data_in = 1'b1;
        cyc(P);
        data_in = 1'b0;
        cyc(P / 2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst on_out", 64'(on0), 64'h0);
        check("async rst note_out", 64'(note0), 64'h0);
        check("async rst velocity_out", 64'(vel0), 64'h0);
        data_in = 1'b1;
        model_reset();
        cyc(3);
        rst = 1'b0;
        cyc(12 * P);
        window();
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        check("post-rst no running status", 64'(on0), 64'h00);
        send3(8'h90, 8'h3C, 8'h64);
        check("post-rst note on", 64'(on0), 64'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
